// File: rtl/bram_ctrl_pkg.sv
// Shared widths, defaults and FSM state encoding for the host-to-BRAM command stage.
package bram_ctrl_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned WE_W   = DATA_W / 8;
    localparam int unsigned LAT_W  = 2;

    localparam logic [ADDR_W-1:0] MAX_ADDR_DEF = 14'h3FFE;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ     = 3'd2,
        RD_WAIT  = 3'd3,
        VERIFY   = 3'd4,
        VFY_WAIT = 3'd5,
        WAIT_REL = 3'd6
    } bram_ctrl_state_t;

endpackage

// File: rtl/bram_lat_cnt.sv
// Loadable down-counter timing the BRAM read latency; done while the count is zero.
module bram_lat_cnt
    import bram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LAT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/bram_wr_ctrl.sv
// Host-to-BRAM command stage: one BRAM access per cs assertion, registered outputs.
// Optional write readback check enabled by defining BRAM_WR_VERIFY_EN.
module bram_wr_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEF,
    parameter int unsigned       RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wbit,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wr_done,
    output logic              addr_err,
    output logic [15:0]       wr_count,
    output logic              verify_err,
    output logic              bram_en,
    output logic [WE_W-1:0]   bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    bram_ctrl_state_t state, state_n;
    logic              cs_q;
    logic              start;
    logic              lat_load, lat_dec, lat_done;
    logic              busy_n, rvalid_n, wr_done_n, addr_err_n, en_n, verr_n;
    logic [WE_W-1:0]   we_n;
    logic [ADDR_W-1:0] baddr_n;
    logic [DATA_W-1:0] bdin_n, rdata_n;
    logic [15:0]       wr_count_n;

`ifdef BRAM_WR_VERIFY_EN
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
`endif

    assign start = (state == IDLE) && cs && !cs_q;

    bram_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .dec      (lat_dec),
        .load_val (LAT_LOAD),
        .done     (lat_done)
    );

    // Outputs are computed for the upcoming state so they register together with it.
    always_comb begin
        state_n    = state;
        en_n       = 1'b0;
        we_n       = '0;
        baddr_n    = bram_addr;
        bdin_n     = bram_din;
        rdata_n    = rdata;
        rvalid_n   = 1'b0;
        wr_done_n  = 1'b0;
        addr_err_n = 1'b0;
        verr_n     = 1'b0;
        wr_count_n = wr_count;
        lat_load   = 1'b0;
        lat_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (addr > MAX_ADDR) begin
                        addr_err_n = 1'b1;
                        state_n    = WAIT_REL;
                    end else if (wbit) begin
                        state_n    = WRITE;
                        en_n       = 1'b1;
                        we_n       = '1;
                        baddr_n    = addr;
                        bdin_n     = wdata;
                        wr_done_n  = 1'b1;
                        wr_count_n = wr_count + 16'd1;
                    end else begin
                        state_n = READ;
                        en_n    = 1'b1;
                        baddr_n = addr;
                    end
                end
            end
            WRITE: begin
`ifdef BRAM_WR_VERIFY_EN
                state_n = VERIFY;
                en_n    = 1'b1;
                baddr_n = op_addr;
`else
                state_n = WAIT_REL;
`endif
            end
            READ: begin
                state_n  = RD_WAIT;
                lat_load = 1'b1;
            end
            RD_WAIT: begin
                if (lat_done) begin
                    rdata_n  = bram_dout;
                    rvalid_n = 1'b1;
                    state_n  = WAIT_REL;
                end else begin
                    lat_dec = 1'b1;
                end
            end
`ifdef BRAM_WR_VERIFY_EN
            VERIFY: begin
                state_n  = VFY_WAIT;
                lat_load = 1'b1;
            end
            VFY_WAIT: begin
                if (lat_done) begin
                    verr_n  = (bram_dout != op_wdata);
                    state_n = WAIT_REL;
                end else begin
                    lat_dec = 1'b1;
                end
            end
`endif
            WAIT_REL: begin
                if (!cs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // cs_q resets high so a cs already held at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cs_q      <= 1'b1;
            busy      <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            wr_done   <= 1'b0;
            addr_err  <= 1'b0;
            wr_count  <= '0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            state     <= state_n;
            cs_q      <= cs;
            busy      <= busy_n;
            rdata     <= rdata_n;
            rvalid    <= rvalid_n;
            wr_done   <= wr_done_n;
            addr_err  <= addr_err_n;
            wr_count  <= wr_count_n;
            bram_en   <= en_n;
            bram_we   <= we_n;
            bram_addr <= baddr_n;
            bram_din  <= bdin_n;
        end
    end

`ifdef BRAM_WR_VERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_addr    <= '0;
            op_wdata   <= '0;
            verify_err <= 1'b0;
        end else begin
            if (start) begin
                op_addr  <= addr;
                op_wdata <= wdata;
            end
            verify_err <= verr_n;
        end
    end
`else
    assign verify_err = 1'b0;
`endif

endmodule
